// File: rtl/goertzel_tone_gen_if.sv
// Stream/control bundle between the Goertzel tone generator and its user.
//   i_start/i_coef/i_seed : block request with resonator coefficient and seed
//   i_ready               : downstream ready
//   o_valid/o_sample/o_last : sample stream, o_last marks sample N-1
//   o_busy/o_done/o_ovf   : status (in block, end-of-block pulse, sticky overflow)
// The slave modport is the generator; the master modport is its user.
interface goertzel_tone_gen_if #(
  parameter int OW = 12,
  parameter int CW = 16
);
  logic                 i_start;
  logic signed [CW-1:0] i_coef;
  logic signed [OW-1:0] i_seed;
  logic                 i_ready;
  logic                 o_valid;
  logic signed [OW-1:0] o_sample;
  logic                 o_last;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_ovf;

  modport slave (
    input  i_start, i_coef, i_seed, i_ready,
    output o_valid, o_sample, o_last, o_busy, o_done, o_ovf
  );

  modport master (
    output i_start, i_coef, i_seed, i_ready,
    input  o_valid, o_sample, o_last, o_busy, o_done, o_ovf
  );
endinterface

// File: rtl/goertzel_tone_gen.sv
// Zero-input 2nd-order resonator used as a sine source for the Goertzel detector.
// Emits blocks of N samples of A*sin(w*k) via s[k] = c*s[k-1] - s[k-2].
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of goertzel_tone_gen_if (request, stream, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for i_start; o_sample keeps the last value
// S_RUN  | presenting s[cnt]; advances on each o_valid & i_ready
module goertzel_tone_gen #(
  parameter int OW    = 12,
  parameter int N     = 60,
  parameter int CW    = 16,
  parameter int GUARD = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  goertzel_tone_gen_if.slave bus
);
  localparam int IW   = OW + GUARD;
  localparam int XW   = CW + IW + 1;
  localparam int CNTW = $clog2(N);

  localparam logic [CNTW-1:0]      CNT_LAST = CNTW'(N - 1);
  localparam logic signed [XW-1:0] RND      = XW'(2 ** (CW - 3));
  localparam logic signed [XW-1:0] I_MAX    = XW'(2 ** (IW - 1) - 1);
  localparam logic signed [XW-1:0] I_MIN    = XW'(-(2 ** (IW - 1)));
  localparam logic signed [IW-1:0] O_MAX    = IW'(2 ** (OW - 1) - 1);
  localparam logic signed [IW-1:0] O_MIN    = IW'(-(2 ** (OW - 1)));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic signed [CW-1:0] coef_q, coef_d;
  logic signed [IW-1:0] cur_q, cur_d;
  logic signed [IW-1:0] prv_q, prv_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic signed [XW-1:0] coef_x, cur_x, prv_x, prod_w, nxt_w;
  logic signed [IW-1:0] nxt_sat, seed_x, out_sat;
  logic                 nxt_clip, nxt_oclip, xfer;

  // Datapath: full-width product, round-half-up arithmetic shift, then clamp.
  always_comb begin
    coef_x = $signed({{(XW-CW){coef_q[CW-1]}}, coef_q});
    cur_x  = $signed({{(XW-IW){cur_q[IW-1]}}, cur_q});
    prv_x  = $signed({{(XW-IW){prv_q[IW-1]}}, prv_q});
    seed_x = $signed({{GUARD{bus.i_seed[OW-1]}}, bus.i_seed});
    prod_w = coef_x * cur_x;
    nxt_w  = ((prod_w + RND) >>> (CW - 2)) - prv_x;

    nxt_clip = 1'b0;
    nxt_sat  = nxt_w[IW-1:0];
    if (nxt_w > I_MAX) begin
      nxt_sat  = I_MAX[IW-1:0];
      nxt_clip = 1'b1;
    end else if (nxt_w < I_MIN) begin
      nxt_sat  = I_MIN[IW-1:0];
      nxt_clip = 1'b1;
    end
    // The output clamp on the new cur is flagged when cur is loaded, so o_ovf
    // rises together with the first clamped sample.
    nxt_oclip = (nxt_sat > O_MAX) || (nxt_sat < O_MIN);

    out_sat = cur_q;
    if (cur_q > O_MAX)      out_sat = O_MAX;
    else if (cur_q < O_MIN) out_sat = O_MIN;
  end

  assign xfer = (state_q == S_RUN) && bus.i_ready;

  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    cur_d   = cur_q;
    prv_d   = prv_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_RUN;
          coef_d  = bus.i_coef;
          cur_d   = '0;
          prv_d   = -seed_x;   // s[-1] = -seed makes s[1] = seed
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            prv_d = cur_q;
            cur_d = nxt_sat;
            cnt_d = cnt_q + CNTW'(1);
            if (nxt_clip || nxt_oclip) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      coef_q  <= '0;
      cur_q   <= '0;
      prv_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      cur_q   <= cur_d;
      prv_q   <= prv_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_valid  = (state_q == S_RUN);
  assign bus.o_busy   = (state_q == S_RUN);
  assign bus.o_last   = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign bus.o_sample = out_sat[OW-1:0];
  assign bus.o_done   = done_q;
  assign bus.o_ovf    = ovf_q;
endmodule
